// File: rtl/bf_loader.sv
// Program loader for the brainfuck core: filters and checks a host byte stream,
// streams the accepted program plus a 0x00 terminator, then forwards runtime input.
`timescale 1ns/1ps
module bf_loader #(
    parameter int MAX_LEN = 255
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] h_data,
    input  logic       h_valid,
    input  logic       h_last,
    output logic       h_ready,
    output logic [7:0] p_data,
    output logic       p_valid,
    input  logic       p_ack,
    output logic       p_start,
    input  logic       p_ready,
    output logic       busy,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_CAPTURE, S_CHECK, S_WAIT_RDY, S_STREAM, S_TERM, S_START, S_RUN_WAIT, S_RUN
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] depth_q, depth_d;
    logic       toolong_q, toolong_d;
    logic       unbal_q, unbal_d;
    logic       err_q, err_d;
    logic [1:0] err_code_q, err_code_d;

    logic [7:0] mem_q [0:MAX_LEN-1];
    logic [7:0] rd_data_q;
    logic       mem_we;

    logic       host_xfer, core_xfer, is_cmd, bad_prog;

    assign host_xfer = h_valid && h_ready;
    assign core_xfer = p_valid && p_ack;
    assign bad_prog  = toolong_q || unbal_q || (depth_q != 8'd0);

    always_comb begin
        case (h_data)
            8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C: is_cmd = 1'b1;
            default:                                                 is_cmd = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q    <= S_CAPTURE;
            len_q      <= 8'd0;
            idx_q      <= 8'd0;
            depth_q    <= 8'd0;
            toolong_q  <= 1'b0;
            unbal_q    <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            depth_q    <= depth_d;
            toolong_q  <= toolong_d;
            unbal_q    <= unbal_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // Read address follows idx_d so rd_data_q already holds buf[idx] when STREAM presents it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[len_q[AW-1:0]] <= h_data;
        end
        rd_data_q <= mem_q[idx_d[AW-1:0]];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CAPTURE:  if (host_xfer && h_last) state_d = S_CHECK;
            S_CHECK:    state_d = bad_prog ? S_CAPTURE : S_WAIT_RDY;
            S_WAIT_RDY: if (p_ready) state_d = (len_q == 8'd0) ? S_TERM : S_STREAM;
            S_STREAM:   if (core_xfer && (idx_q == len_q - 8'd1)) state_d = S_TERM;
            S_TERM:     if (core_xfer) state_d = S_START;
            S_START:    state_d = S_RUN_WAIT;
            S_RUN_WAIT: if (!p_ready) state_d = S_RUN;
            S_RUN:      if (p_ready) state_d = S_CAPTURE;
            default:    state_d = S_CAPTURE;
        endcase
    end

    always_comb begin
        len_d      = len_q;
        idx_d      = idx_q;
        depth_d    = depth_q;
        toolong_d  = toolong_q;
        unbal_d    = unbal_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        mem_we     = 1'b0;
        case (state_q)
            S_CAPTURE: begin
                if (host_xfer) begin
                    err_d      = 1'b0;
                    err_code_d = 2'd0;
                    if (is_cmd) begin
                        if (len_q < MAX_LEN_B) begin
                            mem_we = 1'b1;
                            len_d  = len_q + 8'd1;
                        end else begin
                            toolong_d = 1'b1;
                        end
                    end
                    // Saturating at 255 leaves depth non-zero, which CHECK reports as imbalance.
                    if (h_data == 8'h5B && depth_q != 8'hFF) begin
                        depth_d = depth_q + 8'd1;
                    end else if (h_data == 8'h5D) begin
                        if (depth_q == 8'd0) unbal_d = 1'b1;
                        else                 depth_d = depth_q - 8'd1;
                    end
                end
            end
            S_CHECK: begin
                if (bad_prog) begin
                    err_d      = 1'b1;
                    err_code_d = toolong_q ? 2'd2 : 2'd1;
                    len_d      = 8'd0;
                    depth_d    = 8'd0;
                    toolong_d  = 1'b0;
                    unbal_d    = 1'b0;
                end
            end
            S_WAIT_RDY: idx_d = 8'd0;
            S_STREAM:   if (core_xfer) idx_d = idx_q + 8'd1;
            S_RUN: begin
                if (p_ready) begin
                    len_d     = 8'd0;
                    depth_d   = 8'd0;
                    toolong_d = 1'b0;
                    unbal_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Outputs are forced idle while nrst is low so nothing is handshaken during reset.
    always_comb begin
        h_ready  = 1'b0;
        p_data   = 8'h00;
        p_valid  = 1'b0;
        p_start  = 1'b0;
        busy     = 1'b0;
        err      = 1'b0;
        err_code = 2'd0;
        if (nrst) begin
            busy     = (state_q != S_CAPTURE);
            err      = err_q;
            err_code = err_code_q;
            case (state_q)
                S_CAPTURE: h_ready = 1'b1;
                S_STREAM: begin
                    p_valid = 1'b1;
                    p_data  = rd_data_q;
                end
                S_TERM:  p_valid = 1'b1;
                S_START: p_start = 1'b1;
                S_RUN: begin
                    p_data  = h_data;
                    p_valid = h_valid && !p_ready;
                    h_ready = p_ack && !p_ready;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bf_loader.sv
// Self-checking bench for bf_loader: acts as host and core, compares against a
// string-level model of filtering, length limit and bracket balance.
`timescale 1ns/1ps
module tb_bf_loader;

    localparam int MAXL = 5;
    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [7:0] h_data = 8'h00;
    logic       h_valid = 1'b0;
    logic       h_last = 1'b0;
    logic       h_ready;
    logic [7:0] p_data;
    logic       p_valid;
    logic       p_ack;
    logic       p_start;
    logic       p_ready = 1'b1;
    logic       busy;
    logic       err;
    logic [1:0] err_code;
    logic       ack_en = 1'b0;

    int   vec_cnt = 0;
    int   err_cnt = 0;
    bq_t  rx_q;
    int   start_cnt = 0;
    int   pv_seen = 0;

    always #5 clk = ~clk;

    bf_loader #(.MAX_LEN(MAXL)) dut (
        .clk(clk), .nrst(nrst),
        .h_data(h_data), .h_valid(h_valid), .h_last(h_last), .h_ready(h_ready),
        .p_data(p_data), .p_valid(p_valid), .p_ack(p_ack), .p_start(p_start),
        .p_ready(p_ready), .busy(busy), .err(err), .err_code(err_code)
    );

    assign p_ack = p_valid && ack_en;

    always @(posedge clk) begin
        if (p_valid && p_ack) rx_q.push_back(p_data);
        if (p_start) start_cnt++;
        if (p_valid) pv_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bq_t s2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic bq_t filt(input bq_t s);
        bq_t q;
        foreach (s[i])
            if (s[i] inside {8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C})
                q.push_back(s[i]);
        return q;
    endfunction

    // Too long beats imbalance; balance is the usual never-negative, ends-at-zero rule.
    function automatic int exp_code(input bq_t s);
        bq_t c;
        int d;
        c = filt(s);
        if (c.size() > MAXL) return 2;
        d = 0;
        foreach (c[i]) begin
            if (c[i] == 8'h5B) d++;
            else if (c[i] == 8'h5D) begin
                if (d == 0) return 1;
                d--;
            end
        end
        return (d != 0) ? 1 : 0;
    endfunction

    // Called at a negedge; returns at the negedge after the host transfer.
    task automatic host_byte(input logic [7:0] b, input logic last);
        int n;
        n = 0;
        h_data = b; h_valid = 1'b1; h_last = last;
        #1;
        while (!h_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!h_ready) chk("host_accept_timeout", h_ready, 1);
        @(negedge clk);
        h_valid = 1'b0; h_last = 1'b0;
    endtask

    task automatic send_prog(input bq_t prog);
        foreach (prog[i]) host_byte(prog[i], (i == prog.size() - 1));
    endtask

    task automatic run_prog(input bq_t prog, input logic with_input);
        int code, n;
        bq_t expq;
        code = exp_code(prog);
        expq = filt(prog);
        expq.push_back(8'h00);
        rx_q.delete(); start_cnt = 0; pv_seen = 0; p_ready = 1'b1; ack_en = 1'b0;
        send_prog(prog);
        chk("busy_in_check", busy, 1);
        chk("h_ready_in_check", h_ready, 0);
        if (code != 0) begin
            @(negedge clk);
            chk("err_set", err, 1);
            chk("err_code", err_code, code);
            chk("h_ready_after_err", h_ready, 1);
            chk("busy_after_err", busy, 0);
            repeat (3) @(negedge clk);
            chk("no_p_valid_on_err", pv_seen, 0);
            chk("no_start_on_err", start_cnt, 0);
            host_byte(8'h78, 1'b0);
            chk("err_cleared", err, 0);
            chk("err_code_cleared", err_code, 0);
            return;
        end
        n = 0;
        while (start_cnt == 0 && n < 300) begin
            ack_en = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        ack_en = 1'b0;
        chk("start_seen", start_cnt, 1);
        chk("stream_len", rx_q.size(), expq.size());
        for (int i = 0; i < expq.size() && i < rx_q.size(); i++)
            chk($sformatf("stream_byte%0d", i), rx_q[i], expq[i]);
        chk("err_ok", err, 0);
        chk("busy_running", busy, 1);
        @(negedge clk);
        chk("start_single_pulse", start_cnt, 1);
        chk("p_valid_run_wait", p_valid, 0);
        p_ready = 1'b0;
        @(negedge clk);
        chk("busy_in_run", busy, 1);
        if (with_input) begin
            h_data = 8'h41; h_valid = 1'b1; #1;
            chk("run_p_valid", p_valid, 1);
            chk("run_p_data", p_data, 8'h41);
            chk("run_h_ready_noack", h_ready, 0);
            ack_en = 1'b1; #1;
            chk("run_h_ready_ack", h_ready, 1);
            rx_q.delete();
            @(negedge clk);
            chk("run_fwd_count", rx_q.size(), 1);
            if (rx_q.size() > 0) chk("run_fwd_byte", rx_q[0], 8'h41);
            ack_en = 1'b0; p_ready = 1'b1; #1;
            chk("run_done_p_valid", p_valid, 0);
            chk("run_done_h_ready", h_ready, 0);
        end else begin
            p_ready = 1'b1;
        end
        @(negedge clk);
        h_valid = 1'b0;
        chk("back_busy", busy, 0);
        chk("back_h_ready", h_ready, 1);
    endtask

    initial begin
        string alpha;
        bq_t rp;
        int n;
        alpha = "+-<>[].,ax\n ";
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_h_ready", h_ready, 0);
        chk("rst_p_valid", p_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_p_start", p_start, 0);
        nrst = 1'b1; #1;
        chk("post_rst_h_ready", h_ready, 1);
        chk("post_rst_err_code", err_code, 0);
        @(negedge clk);

        run_prog(s2q("+[-]."), 1'b0);
        run_prog(s2q("a+b\n>"), 1'b0);
        run_prog(s2q("]["), 1'b0);
        run_prog(s2q("++++++"), 1'b0);
        run_prog(s2q("[[[[[]]]]]"), 1'b0);
        run_prog(s2q("x"), 1'b0);
        run_prog(s2q(",."), 1'b1);

        // Reset in the middle of streaming the third program byte.
        rx_q.delete();
        send_prog(s2q("+[-]."));
        n = 0;
        ack_en = 1'b1;
        while (rx_q.size() < 2 && n < 50) begin
            @(negedge clk); n++;
        end
        ack_en = 1'b0;
        chk("pre_rst_count", rx_q.size(), 2);
        chk("pre_rst_p_valid", p_valid, 1);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1; #1;
        chk("mid_rst_p_valid", p_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_h_ready", h_ready, 1);
        chk("mid_rst_err", err, 0);
        @(negedge clk);
        run_prog(s2q("+"), 1'b0);

        for (int t = 0; t < 30; t++) begin
            rp.delete();
            for (int k = 0, m = $urandom_range(1, 9); k < m; k++) begin
                logic [7:0] ch;
                ch = alpha[$urandom_range(0, alpha.len() - 1)];
                rp.push_back(ch);
            end
            run_prog(rp, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
